// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg : shared types and constants for the SDRAM line-prefetch slice
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sdram_pkg;
  localparam int   SDRAM_DW = 16;
  localparam int   SDRAM_AW = 32;
  localparam logic WE_READ  = 1'b1;

  typedef enum logic [2:0] {
    PF_IDLE = 3'd0,
    PF_REQ  = 3'd1,
    PF_ACC  = 3'd2,
    PF_DATA = 3'd3,
    PF_FIN  = 3'd4
  } pf_state_t;
endpackage

`default_nettype wire

// File: rtl/sdram_line_prefetch_if.sv
// ---------------------------------------------------------------------------
// sdram_line_prefetch_if : Wishbone-style link between prefetcher and bridge
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sdram_line_prefetch_if;
  logic                          mem_stb_o;
  logic                          mem_we_o;
  logic                          mem_sel_o;
  logic [sdram_pkg::SDRAM_AW-1:0] mem_addr_o;
  logic [sdram_pkg::SDRAM_DW-1:0] mem_dat_o;
  logic                          mem_cyc_i;
  logic                          mem_stb_i;
  logic [sdram_pkg::SDRAM_DW-1:0] mem_dat_i;

  modport master (
    output mem_stb_o, mem_we_o, mem_sel_o, mem_addr_o, mem_dat_o,
    input  mem_cyc_i, mem_stb_i, mem_dat_i
  );

  modport slave (
    input  mem_stb_o, mem_we_o, mem_sel_o, mem_addr_o, mem_dat_o,
    output mem_cyc_i, mem_stb_i, mem_dat_i
  );
endinterface

`default_nettype wire

// File: rtl/sdram_line_prefetch_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo : synchronous FIFO, registered first-word-fall-through head
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  input  wire logic                       push,
  input  wire logic [WIDTH-1:0]           din,
  input  wire logic                       pop,
  output logic      [WIDTH-1:0]           dout,
  output logic                            empty,
  output logic                            full,
  output logic      [$clog2(DEPTH):0]     count,
  input  wire logic                       flush
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [CNT_W-1:0] count_q, count_d, count_after_pop;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             push_en, pop_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign dout    = dout_q;
  assign push_en = push && !full && !flush;
  assign pop_en  = pop && !empty && !flush;

  always_comb begin
    rd_next         = rd_ptr_q + PTR_W'(pop_en);
    count_after_pop = count_q - CNT_W'(pop_en);
    wr_ptr_d        = wr_ptr_q + PTR_W'(push_en);
    rd_ptr_d        = rd_next;
    count_d         = count_after_pop + CNT_W'(push_en);
    // Head register looks ahead so the new head is visible the cycle after push/pop
    if (count_d == '0)
      dout_d = '0;
    else if (count_after_pop == '0)
      dout_d = din;
    else
      dout_d = mem_q[rd_next];
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      dout_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end
endmodule

`default_nettype wire

// File: rtl/sdram_line_prefetch.sv
// ---------------------------------------------------------------------------
// sdram_line_prefetch : sequential single-word SDRAM reads into a stream FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sdram_line_prefetch
  import sdram_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16,
  parameter int ADDR_STEP  = 1
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic                start,
  input  wire logic                abort,
  input  wire logic [SDRAM_AW-1:0] base_addr,
  input  wire logic [LEN_W-1:0]    len,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic                     out_valid,
  output logic [SDRAM_DW-1:0]      out_data,
  input  wire logic                out_ready,
  sdram_line_prefetch_if.master    bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [2:0] ST_IDLE = PF_IDLE;
  localparam logic [2:0] ST_REQ  = PF_REQ;
  localparam logic [2:0] ST_ACC  = PF_ACC;
  localparam logic [2:0] ST_DATA = PF_DATA;
  localparam logic [2:0] ST_FIN  = PF_FIN;

  logic [2:0]          state_q, state_d;
  logic [SDRAM_AW-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic                abort_flag_q, abort_flag_d;
  logic                aborted_q, aborted_d;
  logic                stb_q, stb_d;
  logic                done_q, done_d;

  logic                fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
  logic [CNT_W-1:0]    fifo_count;
  logic                aborting;
  logic                unused_sigs;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    abort_flag_d = abort_flag_q;
    aborted_d    = aborted_q;
    stb_d        = stb_q;
    done_d       = 1'b0;
    fifo_push    = 1'b0;
    fifo_flush   = 1'b0;
    aborting     = abort_flag_q || abort;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d       = base_addr;
          remaining_d  = len;
          aborted_d    = 1'b0;
          abort_flag_d = 1'b0;
          state_d      = (len == '0) ? ST_FIN : ST_REQ;
        end
      end
      ST_REQ: begin
        if (abort) begin
          aborted_d  = 1'b1;
          fifo_flush = 1'b1;
          state_d    = ST_FIN;
        end else if ((CNT_W'(FIFO_DEPTH) - fifo_count) >= CNT_W'(1)) begin
          stb_d   = 1'b1;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (abort) abort_flag_d = 1'b1;
        // Strobe drops on the same edge that sees cyc, so the bridge cannot re-trigger
        if (bus.mem_cyc_i) begin
          stb_d   = 1'b0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (abort) abort_flag_d = 1'b1;
        if (!bus.mem_cyc_i) begin
          fifo_push   = !aborting;
          addr_d      = addr_q + SDRAM_AW'(ADDR_STEP);
          remaining_d = remaining_q - LEN_W'(1);
          if (aborting) begin
            aborted_d  = 1'b1;
            fifo_flush = 1'b1;
            state_d    = ST_FIN;
          end else if (remaining_q == LEN_W'(1)) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      abort_flag_q <= 1'b0;
      aborted_q    <= 1'b0;
      stb_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      abort_flag_q <= abort_flag_d;
      aborted_q    <= aborted_d;
      stb_q        <= stb_d;
      done_q       <= done_d;
    end
  end

  assign fifo_pop  = !fifo_empty && out_ready;
  assign out_valid = !fifo_empty;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign aborted   = aborted_q;

  assign bus.mem_stb_o  = stb_q;
  assign bus.mem_we_o   = WE_READ;
  assign bus.mem_sel_o  = 1'b1;
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_dat_o  = '0;

  assign unused_sigs = bus.mem_stb_i ^ fifo_full;

  sync_fifo #(
    .WIDTH (SDRAM_DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (bus.mem_dat_i),
    .pop   (fifo_pop),
    .dout  (out_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count),
    .flush (fifo_flush)
  );
endmodule

`default_nettype wire

// File: tb/tb_sdram_line_prefetch.sv
// ---------------------------------------------------------------------------
// tb_sdram_line_prefetch : randomized bench with bridge and consumer models
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sdram_line_prefetch;
  import sdram_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, aborted, out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;

  sdram_line_prefetch_if bus();

  sdram_line_prefetch #(
    .FIFO_DEPTH (DEPTH),
    .LEN_W      (LW),
    .ADDR_STEP  (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          br_delay = 0;
  int          br_hold  = 3;
  logic [31:0] req_q[$];
  int          stb_unstable = 0;
  int          stb_in_cyc   = 0;
  logic [31:0] br_a;

  logic [15:0] rx_q[$];
  logic [15:0] exp_q[$];
  int          ready_mode = 1;
  int          done_cnt   = 0;
  logic        last_aborted = 1'b0;

  // Bridge model: cyc rises br_delay cycles after stb, stays high br_hold cycles,
  // and returns addr^0xA5A5 in the cycle cyc falls.
  initial begin
    bus.mem_cyc_i = 1'b0;
    bus.mem_stb_i = 1'b0;
    bus.mem_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_stb_o && !bus.mem_cyc_i) begin
        br_a = bus.mem_addr_o;
        req_q.push_back(br_a);
        repeat (br_delay) begin
          @(posedge clk); #1;
          if (!bus.mem_stb_o || bus.mem_addr_o !== br_a) stb_unstable++;
        end
        bus.mem_cyc_i = 1'b1;
        repeat (br_hold) begin
          @(posedge clk); #1;
          if (bus.mem_stb_o) stb_in_cyc++;
        end
        bus.mem_cyc_i = 1'b0;
        bus.mem_dat_i = br_a[15:0] ^ 16'hA5A5;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) rx_q.push_back(out_data);
    if (rst_n && done) begin
      done_cnt++;
      last_aborted = aborted;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic build_expect(input logic [31:0] b, input int n);
    logic [31:0] a;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = b + 32'(i);
      exp_q.push_back(a[15:0] ^ 16'hA5A5);
    end
  endtask

  function automatic int data_diffs();
    int d = (rx_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  function automatic int addr_diffs(input logic [31:0] b, input int n);
    int d = (req_q.size() != n) ? 1 : 0;
    for (int i = 0; i < req_q.size() && i < n; i++)
      if (req_q[i] !== b + 32'(i)) d++;
    return d;
  endfunction

  task automatic clear_logs();
    req_q.delete();
    rx_q.delete();
    done_cnt     = 0;
    stb_unstable = 0;
    stb_in_cyc   = 0;
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] l);
    @(posedge clk); #1;
    base_addr = b;
    len       = l;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = $urandom;
    len       = 16'($urandom);
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!out_valid && !busy) break;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (aborted !== 1'b0) begin bad++; $display("FAIL reset_aborted got=%b want=0", aborted); end
    total++; if (bus.mem_stb_o !== 1'b0) begin bad++; $display("FAIL reset_stb got=%b want=0", bus.mem_stb_o); end
    total++; if (bus.mem_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", bus.mem_addr_o); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit seen;
    br_delay = 0; br_hold = 3; ready_mode = 1;
    clear_logs();
    build_expect(32'h100, 4);
    pulse_start(32'h100, 16'd4);
    wait_done(300, seen);
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL basic_done_timeout got=%b want=1", seen); end
    total++; if (last_aborted !== 1'b0) begin bad++; $display("FAIL basic_aborted got=%b want=0", last_aborted); end
    drain(50);
    total++; if (addr_diffs(32'h100, 4) !== 0) begin bad++; $display("FAIL basic_addrs diffs=%0d want=0 nreq=%0d", addr_diffs(32'h100, 4), req_q.size()); end
    total++; if (rx_q.size() < 1 || rx_q[0] !== 16'hA4A5) begin bad++; $display("FAIL basic_first_word got=%h want=a4a5", (rx_q.size() > 0) ? rx_q[0] : 16'hxxxx); end
    total++; if (data_diffs() !== 0) begin bad++; $display("FAIL basic_stream diffs=%0d want=0 nrx=%0d", data_diffs(), rx_q.size()); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", done_cnt); end
    total++; if (stb_in_cyc !== 0) begin bad++; $display("FAIL basic_stb_in_cyc got=%0d want=0", stb_in_cyc); end
    total++; if ({bus.mem_we_o, bus.mem_sel_o, bus.mem_dat_o} !== {1'b1, 1'b1, 16'h0}) begin
      bad++; $display("FAIL basic_bus_consts got we=%b sel=%b dat=%h want 1 1 0", bus.mem_we_o, bus.mem_sel_o, bus.mem_dat_o);
    end
  endtask

  task automatic test_len0();
    clear_logs();
    ready_mode = 1;
    pulse_start($urandom, 16'd0);
    @(negedge clk);
    total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL len0_fin_cycle got busy,done=%b%b want=10", busy, done); end
    @(negedge clk);
    total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL len0_done_cycle got busy,done=%b%b want=01", busy, done); end
    repeat (6) @(negedge clk);
    total++; if (req_q.size() !== 0) begin bad++; $display("FAIL len0_no_req got=%0d want=0", req_q.size()); end
    total++; if (done_cnt !== 1 || last_aborted !== 1'b0) begin bad++; $display("FAIL len0_done got cnt=%0d ab=%b want 1 0", done_cnt, last_aborted); end
  endtask

  task automatic test_backpressure();
    bit seen;
    logic [31:0] b = $urandom;
    br_delay = 1; br_hold = 2; ready_mode = 0;
    clear_logs();
    build_expect(b, 10);
    pulse_start(b, 16'd10);
    repeat (80) @(negedge clk);
    total++; if (req_q.size() !== DEPTH) begin bad++; $display("FAIL bp_stall_reqs got=%0d want=%0d", req_q.size(), DEPTH); end
    total++; if ({busy, bus.mem_stb_o, out_valid} !== 3'b101) begin
      bad++; $display("FAIL bp_stall_state got busy,stb,valid=%b%b%b want=101", busy, bus.mem_stb_o, out_valid);
    end
    total++; if (out_data !== exp_q[0]) begin bad++; $display("FAIL bp_head got=%h want=%h", out_data, exp_q[0]); end
    ready_mode = 2;
    wait_done(2000, seen);
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL bp_done_timeout got=%b want=1", seen); end
    drain(200);
    total++; if (data_diffs() !== 0) begin bad++; $display("FAIL bp_stream diffs=%0d want=0 nrx=%0d", data_diffs(), rx_q.size()); end
    total++; if (addr_diffs(b, 10) !== 0) begin bad++; $display("FAIL bp_addrs diffs=%0d want=0", addr_diffs(b, 10)); end
  endtask

  task automatic test_abort();
    bit seen;
    bit found = 1'b0;
    logic [31:0] b = $urandom;
    br_delay = 0; br_hold = 3; ready_mode = 0;
    clear_logs();
    pulse_start(b, 16'd8);
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk); #2;
      if (req_q.size() == 2 && bus.mem_cyc_i) found = 1'b1;
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL abort_word2_timeout got=%b want=1", found); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL abort_pre_valid got=%b want=1", out_valid); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done(100, seen);
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL abort_done_timeout got=%b want=1", seen); end
    total++; if ({aborted, out_valid, busy} !== 3'b100) begin
      bad++; $display("FAIL abort_done_state got ab,valid,busy=%b%b%b want=100", aborted, out_valid, busy);
    end
    ready_mode = 1;
    repeat (20) @(negedge clk);
    total++; if (req_q.size() !== 2) begin bad++; $display("FAIL abort_no_more_stb got=%0d want=2", req_q.size()); end
    total++; if (rx_q.size() !== 0) begin bad++; $display("FAIL abort_flushed got=%0d words want=0", rx_q.size()); end
  endtask

  task automatic test_delay();
    bit seen;
    logic [31:0] b = $urandom;
    br_delay = 5; br_hold = 2; ready_mode = 1;
    clear_logs();
    build_expect(b, 3);
    pulse_start(b, 16'd3);
    wait_done(300, seen);
    drain(50);
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL delay_done_timeout got=%b want=1", seen); end
    total++; if (stb_unstable !== 0) begin bad++; $display("FAIL delay_stb_hold got=%0d unstable want=0", stb_unstable); end
    total++; if (stb_in_cyc !== 0) begin bad++; $display("FAIL delay_stb_drop got=%0d want=0", stb_in_cyc); end
    total++; if (data_diffs() !== 0) begin bad++; $display("FAIL delay_stream diffs=%0d want=0", data_diffs()); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    logic [31:0] b;
    int n;
    for (int k = 0; k < 6; k++) begin
      b = (k == 0) ? 32'hFFFF_FFFE : $urandom;
      n = (k == 0) ? 4 : $urandom_range(1, 12);
      br_delay = $urandom_range(0, 3);
      br_hold  = $urandom_range(1, 3);
      ready_mode = 2;
      clear_logs();
      build_expect(b, n);
      pulse_start(b, 16'(n));
      @(posedge clk); #1;
      start = 1'b1; base_addr = $urandom; len = 16'($urandom_range(1, 50));
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(2000, seen);
      drain(300);
      total++; if (seen !== 1'b1) begin bad++; $display("FAIL b2b%0d_done_timeout got=%b want=1", k, seen); end
      total++; if (data_diffs() !== 0) begin bad++; $display("FAIL b2b%0d_stream diffs=%0d want=0 n=%0d", k, data_diffs(), n); end
      total++; if (addr_diffs(b, n) !== 0) begin bad++; $display("FAIL b2b%0d_addrs diffs=%0d want=0", k, addr_diffs(b, n)); end
      total++; if (done_cnt !== 1 || last_aborted !== 1'b0) begin bad++; $display("FAIL b2b%0d_done got cnt=%0d ab=%b want 1 0", k, done_cnt, last_aborted); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit found = 1'b0;
    logic [31:0] b = $urandom;
    br_delay = 5; br_hold = 2; ready_mode = 1;
    clear_logs();
    pulse_start($urandom, 16'd5);
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #2;
      if (bus.mem_stb_o) found = 1'b1;
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL rstmid_stb_timeout got=%b want=1", found); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    total++; if ({busy, done, aborted, bus.mem_stb_o, out_valid} !== 5'b0) begin
      bad++; $display("FAIL rstmid_async got busy,done,ab,stb,valid=%b%b%b%b%b want=00000", busy, done, aborted, bus.mem_stb_o, out_valid);
    end
    total++; if ({bus.mem_addr_o, out_data} !== 48'h0) begin
      bad++; $display("FAIL rstmid_async_bus got addr=%h data=%h want 0 0", bus.mem_addr_o, out_data);
    end
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    build_expect(b, 2);
    pulse_start(b, 16'd2);
    wait_done(300, seen);
    drain(50);
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL rstmid_done_timeout got=%b want=1", seen); end
    total++; if (data_diffs() !== 0) begin bad++; $display("FAIL rstmid_stream diffs=%0d want=0 nrx=%0d", data_diffs(), rx_q.size()); end
    total++; if (addr_diffs(b, 2) !== 0) begin bad++; $display("FAIL rstmid_addrs diffs=%0d want=0", addr_diffs(b, 2)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_backpressure();
    test_abort();
    test_delay();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/sdram_line_prefetch.md
Name: sdram_line_prefetch

Overview:
- Upstream Wishbone-style master for the SDRAM bridge (`sdram_wish_if`).
- Given a base address and a word count, it issues sequential single-word reads and buffers the returned 16-bit words in an internal FIFO.
- A downstream consumer (display/DMA stream) drains the FIFO with a valid/ready handshake.
- Keeps at most one bridge transaction outstanding; issues a read only when the FIFO has room for its result.

Parameters:
- FIFO_DEPTH, 16, FIFO word capacity; power of two, ≥2.
- LEN_W, 16, width of the word-count input.
- ADDR_STEP, 1, address increment per word.

Ports:
- clk  in  1  single clock, also drives the bridge's clk_i
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only when busy=0
- abort  in  1  one-cycle pulse; cancels the current line
- base_addr  in  32  first word address, sampled on accepted start
- len  in  LEN_W  number of words, sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of line (normal or aborted)
- aborted  out  1  level; valid with done, 1 if the line was aborted
- out_valid  out  1  FIFO non-empty
- out_data  out  16  FIFO head word
- out_ready  in  1  consumer pop; pop when out_valid&&out_ready
- mem_stb_o  out  1  request strobe to bridge stb_i
- mem_we_o  out  1  to bridge we_i; bus encoding 1=read, 0=write; constant 1
- mem_sel_o  out  1  to bridge sel_i; constant 1
- mem_addr_o  out  32  to bridge addr_i
- mem_dat_o  out  16  to bridge dat_i; constant 0
- mem_cyc_i  in  1  from bridge cyc_o; high while transaction in progress
- mem_stb_i  in  1  from bridge stb_o; unused, ignored
- mem_dat_i  in  16  from bridge dat_o; valid when cyc_i falls after a read

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, aborted=0, mem_stb_o=0, mem_addr_o=0, FIFO empty (out_valid=0, out_data=0).
- States and transitions:
  - IDLE: on start → latch addr=base_addr, remaining=len, aborted=0. If len==0, go to FIN; else go to REQ.
  - REQ: wait until free slots ≥1, i.e. FIFO_DEPTH − count ≥ 1 (no outstanding read here). Then assert mem_stb_o with mem_addr_o=addr and go to ACC.
  - ACC: hold mem_stb_o and addr until mem_cyc_i=1. Then deassert mem_stb_o in that same registered update and go to DATA.
  - DATA: wait for mem_cyc_i=0, i.e. the cycle the 1→0 transition is seen.
    - Capture mem_dat_i into the FIFO (push), unless the abort flag is set.
    - addr += ADDR_STEP (32-bit wrap allowed); remaining −= 1.
    - Go to FIN if remaining becomes 0 or abort is set; else go to REQ.
  - FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- busy=1 in REQ/ACC/DATA/FIN; it drops in the same cycle done pulses.
- Read latency per word: ≥4 cycles (stb → cyc rise → cyc fall → push). Throughput is bounded by the bridge.
- mem_stb_o must be low whenever mem_cyc_i has been seen high. This prevents the bridge re-triggering on return to idle.
- FIFO:
  - Synchronous, registered out_data, first-word fall-through (out_valid the cycle after push).
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - A push is never issued when full; the REQ gating guarantees this.
- abort:
  - In IDLE: ignored.
  - In REQ: go to FIN immediately; no request is issued.
  - In ACC or DATA: set the abort flag. The outstanding bridge transaction completes normally; its data is discarded, then FIN.
  - On abort: flush the FIFO in the cycle FIN is entered. Set aborted=1.
  - abort and start in the same cycle in IDLE: start wins.
- start while busy: ignored. Captured values are unchanged.
- len wrap: remaining is LEN_W bits; max line = 2^LEN_W−1 words.
- out_ready while out_valid=0: no effect.
- The consumer may stall indefinitely; the block stalls in REQ with no bus activity.

Decomposition:
- Package sdram_pkg:
  - state enum pf_state_t {PF_IDLE, PF_REQ, PF_ACC, PF_DATA, PF_FIN}
  - SDRAM_DW=16, SDRAM_AW=32
  - WE_READ=1'b1
- Sub-module sync_fifo (params WIDTH, DEPTH):
  - ports clk, rst_n, push, din, pop, dout, empty, full, count, flush.
  - Reusable by the future write-side block.

Test Plan:
- start, base=0x100, len=4, out_ready=1, bridge model (cyc high 3 cycles, data = addr^0xA5A5) → addrs 0x100..0x103 requested in order. Stream 0xA4A5, 0xA4A4, 0xA4A7, 0xA4A6. One done pulse, aborted=0.
- len=0 → done the cycle after FIN entry, no mem_stb_o ever asserted.
- FIFO_DEPTH=4, len=10, out_ready=0 → exactly 4 transactions, then the block idles in REQ with mem_stb_o=0. Raise out_ready → remaining 6 words arrive, total 10 in order.
- abort pulsed while in DATA on word 2 of len=8 → the transaction finishes, its data is dropped, the FIFO is flushed (out_valid=0). done with aborted=1, no further stb.
- Bridge delays cyc rise by 5 cycles → mem_stb_o and addr are held stable for all 5, and stb drops the cycle after cyc is seen high.
- rst_n asserted low mid-ACC → all outputs at reset values immediately (asynchronously). After release, a new start with len=2 completes correctly.
